// File: rtl/core_host_pkg.sv
// Shared sizes, op codes and FSM state type for the host-side core initiator.
package core_host_pkg;

    localparam int IMG_BYTES   = 2048;
    localparam int CMD_DEPTH   = 16;
    localparam int TIMEOUT_CYC = 4096;

    localparam int OP_W   = 4;
    localparam int DATA_W = 8;
    localparam int OUT_W  = 14;
    localparam int ADDR_W = 11;
    localparam int CNT_W  = $clog2(CMD_DEPTH) + 1;
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [OP_W-1:0]  OP_LOAD  = 4'd0;
    localparam logic [PTR_W-1:0] IMG_LAST = PTR_W'(IMG_BYTES - 1);
    localparam logic [CNT_W-1:0] CMD_MAX  = CNT_W'(CMD_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_STREAM,
        ST_DRAIN,
        ST_FINISH
    } host_state_e;

endpackage

// File: rtl/host_prefetch_fifo.sv
// Two-entry skid buffer between 1-cycle-latency image memory and the core byte port.
// The head register drives the byte port directly; the skid slot absorbs the read already in flight.
module host_prefetch_fifo
    import core_host_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              run,
    input  logic              flush,
    input  logic              in_ready,
    input  logic [DATA_W-1:0] img_data,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_addr,
    output logic              in_valid,
    output logic [DATA_W-1:0] in_data,
    output logic              last_xfer
);

    logic [PTR_W-1:0]  rd_addr;
    logic              inflight, inflight_last;
    logic              head_last;
    logic              skid_vld, skid_last;
    logic [DATA_W-1:0] skid_data;
    logic              pop, fill_head;
    logic [1:0]        occ;

    assign pop       = in_valid & in_ready;
    assign fill_head = ~in_valid | pop;
    assign last_xfer = pop & head_last;
    assign img_addr  = rd_addr[ADDR_W-1:0];

    // Read request looks at this cycle's pop so a full-rate stream needs only two slots.
    assign occ       = {1'b0, in_valid} + {1'b0, skid_vld} + {1'b0, inflight} - {1'b0, pop};
    assign img_rd_en = run & ~flush & (rd_addr <= IMG_LAST) & (occ < 2'd2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_addr       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            in_valid      <= 1'b0;
            in_data       <= '0;
            head_last     <= 1'b0;
            skid_vld      <= 1'b0;
            skid_data     <= '0;
            skid_last     <= 1'b0;
        end else if (flush) begin
            rd_addr       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            in_valid      <= 1'b0;
            in_data       <= '0;
            head_last     <= 1'b0;
            skid_vld      <= 1'b0;
            skid_data     <= '0;
            skid_last     <= 1'b0;
        end else begin
            inflight      <= img_rd_en;
            inflight_last <= img_rd_en & (rd_addr == IMG_LAST);
            if (img_rd_en)
                rd_addr <= rd_addr + 1'b1;
            if (fill_head) begin
                if (skid_vld) begin
                    in_valid  <= 1'b1;
                    in_data   <= skid_data;
                    head_last <= skid_last;
                    skid_vld  <= inflight;
                    skid_data <= img_data;
                    skid_last <= inflight_last;
                end else begin
                    in_valid  <= inflight;
                    head_last <= inflight_last;
                    if (inflight)
                        in_data <= img_data;
                end
            end else if (inflight) begin
                skid_vld  <= 1'b1;
                skid_data <= img_data;
                skid_last <= inflight_last;
            end
        end
    end

endmodule

// File: rtl/core_host_ctrl.sv
// Host initiator: plays a command list into the core, streams image bytes on load ops, sums results.
// Optional watchdog abort is compiled in with HOST_TIMEOUT_EN.
module core_host_ctrl
    import core_host_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_cmd_wr_en,
    input  logic [3:0]        i_cmd_wr_addr,
    input  logic [OP_W-1:0]   i_cmd_wr_data,
    input  logic [CNT_W-1:0]  i_cmd_count,
    output logic              o_img_rd_en,
    output logic [ADDR_W-1:0] o_img_addr,
    input  logic [DATA_W-1:0] i_img_data,
    output logic              o_op_valid,
    output logic [OP_W-1:0]   o_op_mode,
    input  logic              i_op_ready,
    output logic              o_in_valid,
    output logic [DATA_W-1:0] o_in_data,
    input  logic              i_in_ready,
    input  logic              i_out_valid,
    input  logic [OUT_W-1:0]  i_out_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [15:0]       o_result_count,
    output logic [15:0]       o_checksum
);

    host_state_e      state, state_nxt;
    logic [OP_W-1:0]  cmd_list [CMD_DEPTH];
    logic [CNT_W-1:0] idx, cnt, start_cnt;
    logic             op_xfer, last_xfer, timeout;

    assign op_xfer   = o_op_valid & i_op_ready;
    assign start_cnt = (i_cmd_count > CMD_MAX) ? CMD_MAX : i_cmd_count;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (i_start) state_nxt = (start_cnt == '0) ? ST_FINISH : ST_FETCH;
            ST_FETCH:  state_nxt = ST_ISSUE;
            ST_ISSUE:  if (op_xfer) state_nxt = (o_op_mode == OP_LOAD) ? ST_STREAM : ST_DRAIN;
            ST_STREAM: if (last_xfer) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (i_op_ready) state_nxt = (idx + 1'b1 == cnt) ? ST_FINISH : ST_FETCH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (timeout)
            state_nxt = ST_FINISH;
    end

    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            cnt            <= '0;
            o_op_valid     <= 1'b0;
            o_op_mode      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_result_count <= '0;
            o_checksum     <= '0;
        end else begin
            state      <= state_nxt;
            o_busy     <= (state_nxt != ST_IDLE);
            o_done     <= (state_nxt == ST_FINISH);
            o_op_valid <= (state_nxt == ST_ISSUE);
            if (state == ST_FETCH)
                o_op_mode <= cmd_list[idx[3:0]];
            if (state == ST_DRAIN && i_op_ready)
                idx <= idx + 1'b1;
            if (state == ST_IDLE && i_start) begin
                idx            <= '0;
                cnt            <= start_cnt;
                o_result_count <= '0;
                o_checksum     <= '0;
            end else if (state != ST_IDLE && i_out_valid) begin
                if (o_result_count != 16'hFFFF)
                    o_result_count <= o_result_count + 16'd1;
                o_checksum <= o_checksum + {2'b00, i_out_data};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_cmd_wr_en && state == ST_IDLE)
            cmd_list[i_cmd_wr_addr] <= i_cmd_wr_data;
    end

    host_prefetch_fifo u_prefetch (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .run       (state == ST_STREAM),
        .flush     (state_nxt != ST_STREAM),
        .in_ready  (i_in_ready),
        .img_data  (i_img_data),
        .img_rd_en (o_img_rd_en),
        .img_addr  (o_img_addr),
        .in_valid  (o_in_valid),
        .in_data   (o_in_data),
        .last_xfer (last_xfer)
    );

`ifdef HOST_TIMEOUT_EN
    localparam int               WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_live, progress;

    assign wd_live  = state inside {ST_ISSUE, ST_STREAM, ST_DRAIN};
    assign progress = op_xfer | (o_in_valid & i_in_ready) | i_out_valid;
    assign timeout  = wd_live & ~progress & (wd_cnt == WD_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt  <= '0;
            o_error <= 1'b0;
        end else begin
            wd_cnt <= (!wd_live || progress) ? '0 : wd_cnt + 1'b1;
            if (state == ST_IDLE && i_start)
                o_error <= 1'b0;
            else if (timeout)
                o_error <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign o_error = 1'b0;
`endif

endmodule
